// File: rtl/wb_stream_master_pkg.sv
// Frame command codes, response status codes and FSM encoding for the
// byte-stream Wishbone master.
package wb_stream_master_pkg;

    localparam logic [7:0] CMD_WR     = 8'h57;
    localparam logic [7:0] CMD_RD     = 8'h52;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_TIMEOUT = 8'hEE;
    localparam logic [7:0] ST_BADCMD  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

endpackage

// File: rtl/wb_stream_master.sv
// Wishbone classic master: parses host byte frames into single 32-bit
// read/write cycles and streams back a status byte plus read data.
module wb_stream_master
    import wb_stream_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [1:0]  byte_idx;
    logic [1:0]  idx_nxt;
    logic [15:0] to_cnt;
    logic        is_wr;
    logic        we_r;
    logic        cyc;
    logic        data_phase;
    logic [7:0]  status;
    logic [31:0] adr_buf, dat_buf, rd_data;
    logic        rx_fire, tx_fire, bus_ack, bus_to, has_data, resp_last;

    assign rx_ready  = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
    assign rx_fire   = rx_valid & rx_ready;
    assign tx_fire   = tx_valid & tx_ready;
    assign bus_ack   = (state == S_BUS) && wbm_ack_i;
    // Ack takes priority over an expiring counter.
    assign bus_to    = (state == S_BUS) && !wbm_ack_i && (to_cnt == TO_LAST);
    assign has_data  = !is_wr && (status != ST_BADCMD);
    assign resp_last = tx_fire && (data_phase ? (byte_idx == 2'd3) : !has_data);
    assign idx_nxt   = byte_idx + 2'd1;

    assign wbm_cyc_o = cyc;
    assign wbm_stb_o = cyc;
    assign wbm_we_o  = cyc & we_r;
    assign wbm_sel_o = {4{cyc}};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (rx_valid)
                state_nxt = (rx_data == CMD_WR || rx_data == CMD_RD) ? S_ADDR : S_RESP;
            S_ADDR: if (rx_valid && byte_idx == 2'd3)
                state_nxt = is_wr ? S_DATA : S_BUS;
            S_DATA: if (rx_valid && byte_idx == 2'd3)
                state_nxt = S_BUS;
            S_BUS:  if (bus_ack || bus_to)
                state_nxt = S_RESP;
            S_RESP: if (resp_last)
                state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            byte_idx   <= '0;
            to_cnt     <= '0;
            is_wr      <= 1'b0;
            we_r       <= 1'b0;
            cyc        <= 1'b0;
            data_phase <= 1'b0;
            status     <= ST_OK;
            adr_buf    <= '0;
            dat_buf    <= '0;
            rd_data    <= '0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
        end else begin
            case (state)
                S_IDLE: if (rx_fire) begin
                    is_wr      <= (rx_data == CMD_WR);
                    byte_idx   <= '0;
                    data_phase <= 1'b0;
                    if (rx_data != CMD_WR && rx_data != CMD_RD) begin
                        status   <= ST_BADCMD;
                        tx_valid <= 1'b1;
                        tx_data  <= ST_BADCMD;
                    end
                end
                S_ADDR: if (rx_fire) begin
                    adr_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
                    byte_idx <= idx_nxt;
                    if (byte_idx == 2'd3 && !is_wr) begin
                        cyc       <= 1'b1;
                        we_r      <= 1'b0;
                        wbm_adr_o <= {rx_data, adr_buf[23:0]};
                        to_cnt    <= '0;
                    end
                end
                S_DATA: if (rx_fire) begin
                    dat_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
                    byte_idx <= idx_nxt;
                    if (byte_idx == 2'd3) begin
                        cyc       <= 1'b1;
                        we_r      <= 1'b1;
                        wbm_adr_o <= adr_buf;
                        wbm_dat_o <= {rx_data, dat_buf[23:0]};
                        to_cnt    <= '0;
                    end
                end
                S_BUS: begin
                    if (bus_ack) begin
                        cyc        <= 1'b0;
                        we_r       <= 1'b0;
                        rd_data    <= wbm_dat_i;
                        status     <= ST_OK;
                        tx_valid   <= 1'b1;
                        tx_data    <= ST_OK;
                        data_phase <= 1'b0;
                    end else if (bus_to) begin
                        cyc        <= 1'b0;
                        we_r       <= 1'b0;
                        rd_data    <= '0;
                        status     <= ST_TIMEOUT;
                        tx_valid   <= 1'b1;
                        tx_data    <= ST_TIMEOUT;
                        data_phase <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_RESP: if (tx_fire) begin
                    // Each accepted byte loads its successor, so the next byte
                    // appears the cycle after the handshake.
                    if (!data_phase) begin
                        if (has_data) begin
                            data_phase <= 1'b1;
                            byte_idx   <= '0;
                            tx_data    <= rd_data[7:0];
                        end else begin
                            tx_valid <= 1'b0;
                        end
                    end else if (byte_idx == 2'd3) begin
                        tx_valid   <= 1'b0;
                        data_phase <= 1'b0;
                        byte_idx   <= '0;
                    end else begin
                        tx_data  <= rd_data[{idx_nxt, 3'b000} +: 8];
                        byte_idx <= idx_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stream_master.sv
// Directed bench for wb_stream_master: write, read, timeout, bad command,
// tx backpressure and reset during a bus cycle.
module tb_wb_stream_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic        ack;
    logic [31:0] dat_i;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_stream_master #(.TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wbm_cyc_o(cyc),
        .wbm_stb_o(stb),
        .wbm_we_o (we),
        .wbm_sel_o(sel),
        .wbm_adr_o(adr),
        .wbm_dat_o(dat_o),
        .wbm_ack_i(ack),
        .wbm_dat_i(dat_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                              input logic [31:0] d);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (cmd == 8'h57)
            for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        tx_ready = 1'b1;
        while (!tx_valid && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
        chk(tag, 32'(tx_data), 32'(exp));
        step();
        tx_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        ack = 1'b0; dat_i = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);

        // ack outside a bus cycle must be ignored
        ack = 1'b1; step(); ack = 1'b0;
        chk("idle_ack_tx_valid", 32'(tx_valid), 32'd0);
        chk("idle_ack_rx_ready", 32'(rx_ready), 32'd1);

        // write, ack on third bus cycle
        send_frame(8'h57, 32'h3000_0000, 32'hDEAD_BEEF);
        chk("wr_cyc", 32'(cyc), 32'd1);
        chk("wr_stb", 32'(stb), 32'd1);
        chk("wr_we", 32'(we), 32'd1);
        chk("wr_sel", 32'(sel), 32'hF);
        chk("wr_adr", adr, 32'h3000_0000);
        chk("wr_dat", dat_o, 32'hDEAD_BEEF);
        chk("wr_rx_ready", 32'(rx_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("wr_hold_cyc", 32'(cyc), 32'd1);
            chk("wr_hold_adr", adr, 32'h3000_0000);
        end
        ack = 1'b1; step(); ack = 1'b0;
        chk("wr_end_cyc", 32'(cyc), 32'd0);
        chk("wr_end_we", 32'(we), 32'd0);
        chk("wr_end_sel", 32'(sel), 32'd0);
        chk("wr_end_adr_hold", adr, 32'h3000_0000);
        recv_byte("wr_status", 8'h00);
        chk("wr_done_rx_ready", 32'(rx_ready), 32'd1);

        // read with immediate ack
        send_frame(8'h52, 32'h3000_0004, 32'h0);
        chk("rd_cyc", 32'(cyc), 32'd1);
        chk("rd_we", 32'(we), 32'd0);
        chk("rd_adr", adr, 32'h3000_0004);
        chk("rd_dat_hold", dat_o, 32'hDEAD_BEEF);
        ack = 1'b1; dat_i = 32'h1234_5678; step(); ack = 1'b0; dat_i = '0;
        chk("rd_end_cyc", 32'(cyc), 32'd0);
        recv_byte("rd_status", 8'h00);
        recv_byte("rd_b0", 8'h78);
        recv_byte("rd_b1", 8'h56);
        recv_byte("rd_b2", 8'h34);
        chk("rd_mid_rx_ready", 32'(rx_ready), 32'd0);
        recv_byte("rd_b3", 8'h12);
        chk("rd_done_rx_ready", 32'(rx_ready), 32'd1);
        chk("rd_done_tx_valid", 32'(tx_valid), 32'd0);

        // timeout: no ack, cyc must stay high exactly 8 cycles
        send_frame(8'h52, 32'h0000_0100, 32'h0);
        cnt = 0;
        while (cyc && cnt < 50) begin
            cnt++;
            step();
        end
        chk("to_cyc_len", 32'(cnt), 32'd8);
        recv_byte("to_status", 8'hEE);
        for (int i = 0; i < 4; i++) recv_byte("to_data", 8'h00);
        chk("to_done_rx_ready", 32'(rx_ready), 32'd1);

        // bad command
        send_byte(8'h41);
        chk("bad_cyc", 32'(cyc), 32'd0);
        chk("bad_tx_valid", 32'(tx_valid), 32'd1);
        recv_byte("bad_status", 8'hFF);
        chk("bad_rx_ready", 32'(rx_ready), 32'd1);
        chk("bad_tx_idle", 32'(tx_valid), 32'd0);
        chk("bad_no_cyc", 32'(cyc), 32'd0);

        // read with tx backpressure
        send_frame(8'h52, 32'h3000_0008, 32'h0);
        ack = 1'b1; dat_i = 32'hAABB_CCDD; step(); ack = 1'b0; dat_i = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_st_valid", 32'(tx_valid), 32'd1);
            chk("bp_st_data", 32'(tx_data), 32'h00);
            chk("bp_st_rx_ready", 32'(rx_ready), 32'd0);
        end
        recv_byte("bp_status", 8'h00);
        recv_byte("bp_b0", 8'hDD);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_b1_valid", 32'(tx_valid), 32'd1);
            chk("bp_b1_data", 32'(tx_data), 32'hCC);
        end
        recv_byte("bp_b1", 8'hCC);
        recv_byte("bp_b2", 8'hBB);
        chk("bp_mid_rx_ready", 32'(rx_ready), 32'd0);
        recv_byte("bp_b3", 8'hAA);
        chk("bp_done_rx_ready", 32'(rx_ready), 32'd1);

        // reset while a bus cycle is in flight
        send_frame(8'h57, 32'h3000_0010, 32'h0403_0201);
        chk("rst_mid_cyc_pre", 32'(cyc), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_cyc", 32'(cyc), 32'd0);
        chk("rst_mid_stb", 32'(stb), 32'd0);
        chk("rst_mid_adr", adr, 32'd0);
        chk("rst_mid_rx_ready", 32'(rx_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_mid_no_tx", 32'(tx_valid), 32'd0);
        end
        send_frame(8'h57, 32'h3000_0020, 32'h1122_3344);
        chk("post_rst_adr", adr, 32'h3000_0020);
        chk("post_rst_dat", dat_o, 32'h1122_3344);
        chk("post_rst_we", 32'(we), 32'd1);
        ack = 1'b1; step(); ack = 1'b0;
        recv_byte("post_rst_status", 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
